// File: rtl/tt_um_rps_match.sv
// Best-of-N stone-paper-scissors match controller (TinyTapeout user module).
// Judges rounds from two 2-bit moves, keeps per-player scores and a round count, declares a match winner.
module tt_um_rps_match #(
    parameter int WIN_TARGET = 3,
    parameter int SCORE_W    = 4,
    parameter int MAX_ROUNDS = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int RC_W = $clog2(MAX_ROUNDS + 1);
    localparam logic [SCORE_W-1:0] WIN_T  = SCORE_W'(WIN_TARGET);
    localparam logic [RC_W-1:0]    RC_MAX = RC_W'(MAX_ROUNDS);

    typedef enum logic [1:0] {IDLE = 2'b00, EVAL = 2'b01, RESULT = 2'b10, DONE = 2'b11} state_t;
    typedef enum logic [1:0] {STONE = 2'b00, PAPER = 2'b01, SCISSORS = 2'b10, INVALID = 2'b11} move_t;

    localparam logic [1:0] RES_TIE = 2'b00;
    localparam logic [1:0] RES_P1  = 2'b01;
    localparam logic [1:0] RES_P2  = 2'b10;
    localparam logic [1:0] RES_INV = 2'b11;

    function automatic logic [1:0] judge(input logic [1:0] a, input logic [1:0] b);
        if (a == INVALID || b == INVALID) return RES_INV;
        if (a == b) return RES_TIE;
        if ((a == STONE && b == SCISSORS) || (a == SCISSORS && b == PAPER) ||
            (a == PAPER && b == STONE)) return RES_P1;
        return RES_P2;
    endfunction

    state_t             state_q, state_d;
    logic               start_q, start_d;
    logic [1:0]         mv1_q, mv1_d, mv2_q, mv2_d;
    logic [SCORE_W-1:0] score1_q, score1_d, score2_q, score2_d;
    logic [RC_W-1:0]    rounds_q, rounds_d;
    logic [1:0]         result_q, result_d;
    logic               valid_q, valid_d;
    logic               over_q, over_d;
    logic [1:0]         winner_q, winner_d;

    logic               go, clear;
    logic [1:0]         round_res;
    logic [SCORE_W-1:0] s1_n, s2_n;
    logic [RC_W-1:0]    rc_n;
    logic               decided;
    logic [1:0]         win_n;

    assign go    = ui_in[4] & ~start_q;
    assign clear = ui_in[5];

    // Post-round counters and the match decision, consumed only in EVAL.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        round_res = judge(mv1_q, mv2_q);
        s1_n      = score1_q;
        s2_n      = score2_q;
        rc_n      = rounds_q;
        decided   = 1'b0;
        win_n     = 2'b00;
        if (round_res != RES_INV) begin
            if (rounds_q != RC_MAX) rc_n = rounds_q + RC_W'(1);
            if (round_res == RES_P1) s1_n = score1_q + SCORE_W'(1);
            if (round_res == RES_P2) s2_n = score2_q + SCORE_W'(1);
        end
        if (s1_n == WIN_T) begin
            decided = 1'b1;
            win_n   = RES_P1;
        end else if (s2_n == WIN_T) begin
            decided = 1'b1;
            win_n   = RES_P2;
        end else if (rc_n == RC_MAX) begin
            decided = 1'b1;
            if (s1_n > s2_n)      win_n = RES_P1;
            else if (s2_n > s1_n) win_n = RES_P2;
        end
    end

    always_comb begin
        state_d  = state_q;
        start_d  = start_q;
        mv1_d    = mv1_q;
        mv2_d    = mv2_q;
        score1_d = score1_q;
        score2_d = score2_q;
        rounds_d = rounds_q;
        result_d = result_q;
        valid_d  = valid_q;
        over_d   = over_q;
        winner_d = winner_q;
        if (ena) begin
            start_d = ui_in[4];
            valid_d = 1'b0;
            if (clear) begin
                state_d  = IDLE;
                score1_d = '0;
                score2_d = '0;
                rounds_d = '0;
                result_d = 2'b00;
                over_d   = 1'b0;
                winner_d = 2'b00;
            end else begin
                unique case (state_q)
                    IDLE: if (go) begin
                        state_d = EVAL;
                        mv1_d   = ui_in[1:0];
                        mv2_d   = ui_in[3:2];
                    end
                    EVAL: begin
                        result_d = round_res;
                        valid_d  = 1'b1;
                        score1_d = s1_n;
                        score2_d = s2_n;
                        rounds_d = rc_n;
                        over_d   = decided;
                        winner_d = win_n;
                        state_d  = decided ? DONE : RESULT;
                    end
                    // A new round needs start released and raised again.
                    RESULT: if (!ui_in[4]) state_d = IDLE;
                    DONE: if (go) begin
                        state_d  = IDLE;
                        score1_d = '0;
                        score2_d = '0;
                        rounds_d = '0;
                        over_d   = 1'b0;
                        winner_d = 2'b00;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            start_q  <= 1'b0;
            mv1_q    <= 2'b00;
            mv2_q    <= 2'b00;
            score1_q <= '0;
            score2_q <= '0;
            rounds_q <= '0;
            result_q <= 2'b00;
            valid_q  <= 1'b0;
            over_q   <= 1'b0;
            winner_q <= 2'b00;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q  <= state_d;
            start_q  <= start_d;
            mv1_q    <= mv1_d;
            mv2_q    <= mv2_d;
            score1_q <= score1_d;
            score2_q <= score2_d;
            rounds_q <= rounds_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            over_q   <= over_d;
            winner_q <= winner_d;
        end
    end

    assign uo_out  = {state_q, winner_q, over_q, valid_q, result_q};
    assign uio_out = {4'(score2_q), 4'(score1_q)};
    assign uio_oe  = 8'hFF;

    logic unused_inputs;
    assign unused_inputs = &{1'b0, uio_in, ui_in[7:6]};

endmodule

// File: tb/tb_tt_um_rps_match.sv
// Self-checking bench for tt_um_rps_match: a scoreboard of expected round outcomes is filled
// as rounds are started and drained whenever the DUT pulses result_valid.
module tb_tt_um_rps_match;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    tt_um_rps_match dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] res;
        logic [3:0] s1;
        logic [3:0] s2;
        logic       over;
        logic [1:0] win;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   m_s1 = 0, m_s2 = 0, m_rc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: rock-paper-scissors outcome via (m1 - m2) mod 3.
    task automatic model_round(input logic [1:0] m1, input logic [1:0] m2);
        exp_t e;
        int   d;
        e = '0;
        if (m1 == 2'b11 || m2 == 2'b11) begin
            e.res = 2'b11;
        end else begin
            d = (int'(m1) - int'(m2) + 3) % 3;
            e.res = 2'(d);
            if (m_rc < 15) m_rc++;
            if (d == 1) m_s1++;
            if (d == 2) m_s2++;
        end
        e.s1 = 4'(m_s1);
        e.s2 = 4'(m_s2);
        if (m_s1 == 3)       begin e.over = 1'b1; e.win = 2'b01; end
        else if (m_s2 == 3)  begin e.over = 1'b1; e.win = 2'b10; end
        else if (m_rc == 15) begin
            e.over = 1'b1;
            e.win  = (m_s1 > m_s2) ? 2'b01 : (m_s2 > m_s1) ? 2'b10 : 2'b00;
        end
        sb.push_back(e);
    endtask

    task automatic model_clear();
        m_s1 = 0;
        m_s2 = 0;
        m_rc = 0;
    endtask

    // Scoreboard drain: one expected entry per result_valid pulse.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && uo_out[2]) begin
            check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("result", 32'(uo_out[1:0]), 32'(e.res));
                check("scores", 32'(uio_out), 32'({e.s2, e.s1}));
                check("match_over", 32'(uo_out[3]), 32'(e.over));
                check("winner", 32'(uo_out[5:4]), 32'(e.win));
                check("state_after_eval", 32'(uo_out[7:6]), e.over ? 32'd3 : 32'd2);
            end
        end
    end

    task automatic do_reset();
        ui_in = 8'h00;
        ena   = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_uo_out", 32'(uo_out), 32'h00);
        check("rst_uio_out", 32'(uio_out), 32'h00);
        check("uio_oe", 32'(uio_oe), 32'hFF);
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);
    endtask

    task automatic play_round(input logic [1:0] m1, input logic [1:0] m2);
        @(negedge clk);
        ui_in = {4'b0001, m2, m1};
        model_round(m1, m2);
        @(negedge clk);
        ui_in[4] = 1'b0;
        check("state_eval", 32'(uo_out[7:6]), 32'd1);
        @(negedge clk);
        @(negedge clk);
        check("valid_pulse_cleared", 32'(uo_out[2]), 32'd0);
    endtask

    task automatic done_go();
        @(negedge clk);
        ui_in[4] = 1'b1;
        @(negedge clk);
        ui_in[4] = 1'b0;
        check("done_go_state", 32'(uo_out[7:6]), 32'd0);
        check("done_go_scores", 32'(uio_out), 32'h00);
        check("done_go_over", 32'(uo_out[3]), 32'd0);
        check("done_go_winner", 32'(uo_out[5:4]), 32'd0);
        model_clear();
        @(negedge clk);
        check("done_go_no_round", 32'(uo_out[7:6]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // First round: stone vs scissors -> P1.
        play_round(2'b00, 2'b10);

        // Three P2 wins from fresh reset, then the match-over go.
        do_reset();
        repeat (3) play_round(2'b01, 2'b10);
        check("done_uio", 32'(uio_out), 32'h30);
        check("done_state", 32'(uo_out[7:6]), 32'd3);
        done_go();

        // Invalid round leaves counters alone; tie bumps round count.
        play_round(2'b11, 2'b00);
        play_round(2'b01, 2'b01);

        // 15 ties -> draw at MAX_ROUNDS.
        do_reset();
        repeat (15) play_round(2'b01, 2'b01);
        check("draw_over", 32'(uo_out[3]), 32'd1);
        done_go();

        // MAX_ROUNDS reached with P1 ahead 1:0.
        repeat (13) play_round(2'b10, 2'b10);
        play_round(2'b00, 2'b10);
        play_round(2'b00, 2'b00);
        check("maxr_winner", 32'(uo_out[5:4]), 32'd1);
        done_go();

        // Start held high 10 cycles: exactly one round, then clear during RESULT.
        @(negedge clk);
        ui_in = 8'b0001_0100;
        model_round(2'b00, 2'b01);
        repeat (10) @(negedge clk);
        check("held_state_result", 32'(uo_out[7:6]), 32'd2);
        check("held_one_round", 32'(sb.size()), 32'd0);
        ui_in[5] = 1'b1;
        @(negedge clk);
        check("clear_uo_out", 32'(uo_out), 32'h00);
        check("clear_uio_out", 32'(uio_out), 32'h00);
        ui_in = 8'h00;
        model_clear();

        // ena dropped during EVAL for 5 cycles.
        play_round(2'b00, 2'b10);
        @(negedge clk);
        ui_in = 8'b0001_0110;
        model_round(2'b10, 2'b01);
        @(negedge clk);
        ena      = 1'b0;
        ui_in[4] = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("frozen_state", 32'(uo_out[7:6]), 32'd1);
            check("frozen_valid", 32'(uo_out[2]), 32'd0);
            check("frozen_uio", 32'(uio_out), 32'h01);
        end
        ena = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("resume_valid_cleared", 32'(uo_out[2]), 32'd0);

        // Asynchronous reset mid-match.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_uo_out", 32'(uo_out), 32'h00);
        check("async_rst_uio_out", 32'(uio_out), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
